vram_arbiter: RTL

//  Shares the single-port 64Kx16 VRAM between three requesters: video fetch, host register interface and blitter.

---
 rtl/vram_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// Three-way arbiter for the single-port 64Kx16 VRAM: video > regs > blit, one grant per cycle,
// registered VRAM port and owner-tagged read return. Define VRAM_ARB_FAIRNESS_EN to cap video streaks.
module vram_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic        vid_ack,
  input  logic        regs_req,
  input  logic        regs_wr,
  input  logic [3:0]  regs_mask,
  input  logic [15:0] regs_addr,
  input  logic [15:0] regs_wdata,
  output logic        regs_ack,
  input  logic        blit_req,
  input  logic        blit_wr,
  input  logic [3:0]  blit_mask,
  input  logic [15:0] blit_addr,
  input  logic [15:0] blit_wdata,
  output logic        blit_ack,
  output logic        rd_valid,
  output logic [1:0]  rd_owner,
  output logic [15:0] rd_data,
  output logic        vram_sel,
  output logic        vram_wr,
  output logic [3:0]  vram_mask,
  output logic [15:0] vram_addr,
  output logic [15:0] vram_wdata,
  input  logic [15:0] vram_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_REGS = 2'd2,
    OWN_BLIT = 2'd3
  } owner_e;

  owner_e win;
  logic   other_pend;
  logic   deny_vid;

  assign other_pend = regs_req | blit_req;

`ifdef VRAM_ARB_FAIRNESS_EN
  logic [3:0] wait_cnt_q, wait_cnt_d;

  assign deny_vid = other_pend && (wait_cnt_q == 4'(MAX_WAIT));

  // Counts video grants that overtook a waiting regs/blit request; any other outcome restarts it.
  always_comb begin
    wait_cnt_d = 4'd0;
    if (other_pend && win == OWN_VID) wait_cnt_d = wait_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wait_cnt_q <= 4'd0;
    else          wait_cnt_q <= wait_cnt_d;
  end
`else
  assign deny_vid = 1'b0;
`endif

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    win = OWN_NONE;
    if (vid_req && !deny_vid) win = OWN_VID;
    else if (regs_req)        win = OWN_REGS;
    else if (blit_req)        win = OWN_BLIT;
  end

  // Acks are forced low while reset is asserted so every output reads 0 immediately.
  assign vid_ack  = reset_n && (win == OWN_VID);
  assign regs_ack = reset_n && (win == OWN_REGS);
  assign blit_ack = reset_n && (win == OWN_BLIT);

  logic        sel_q, sel_d;
  logic        wr_q, wr_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  owner_e      s1_owner_q;
  logic        s1_read_q;
  logic        rd_valid_q;
  owner_e      rd_owner_q;

  always_comb begin
    sel_d   = 1'b1;
    wr_d    = 1'b0;
    mask_d  = 4'd0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (win)
      OWN_VID: addr_d = vid_addr;
      OWN_REGS: begin
        wr_d    = regs_wr;
        mask_d  = regs_wr ? regs_mask : 4'd0;
        addr_d  = regs_addr;
        wdata_d = regs_wdata;
      end
      OWN_BLIT: begin
        wr_d    = blit_wr;
        mask_d  = blit_wr ? blit_mask : 4'd0;
        addr_d  = blit_addr;
        wdata_d = blit_wdata;
      end
      default: sel_d = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q      <= 1'b0;
      wr_q       <= 1'b0;
      mask_q     <= 4'd0;
      addr_q     <= 16'd0;
      wdata_q    <= 16'd0;
      s1_owner_q <= OWN_NONE;
      s1_read_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_owner_q <= OWN_NONE;
    end else begin
      sel_q      <= sel_d;
      wr_q       <= wr_d;
      mask_q     <= mask_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      s1_owner_q <= win;
      s1_read_q  <= sel_d && !wr_d;
      rd_valid_q <= s1_read_q;
      rd_owner_q <= s1_read_q ? s1_owner_q : OWN_NONE;
    end
  end

  assign vram_sel   = sel_q;
  assign vram_wr    = wr_q;
  assign vram_mask  = mask_q;
  assign vram_addr  = addr_q;
  assign vram_wdata = wdata_q;
  assign rd_valid   = rd_valid_q;
  assign rd_owner   = rd_owner_q;
  assign rd_data    = rd_valid_q ? vram_rdata : 16'd0;

endmodule
